// File: rtl/bitwise_logic_unit_pkg.sv
// Shared definitions for the bitwise logic unit: operation encodings and
// the controller state enumeration.
package logic_unit_pkg;

    // Operation select encodings carried on the op port.
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bitwise_logic_unit_slice.sv
// One SLICE-bit wide bitwise operator. The top shares a single instance
// across all slices, steering operand bits in through index muxes.
module logic_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [1:0]       op,
    output logic [SLICE-1:0] y
);
    import logic_unit_pkg::*;

    // Select the requested bitwise function for this slice.
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise unit (AND/OR/XOR/NOR). Operands are captured on
// start and processed SLICE bits per cycle over WIDTH/SLICE cycles; a
// one-cycle done pulse marks result and zero as valid.
module bitwise_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    import logic_unit_pkg::*;

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

    state_t            state_r;
    logic [IDXW-1:0]   idx_r;
    logic [1:0]        op_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [WIDTH-1:0]  result_r;
    logic              zero_r;
    logic              ready_r;
    logic              busy_r;
    logic              done_r;

    logic [31:0]       shamt_s;
    logic [SLICE-1:0]  a_slice_s;
    logic [SLICE-1:0]  b_slice_s;
    logic [SLICE-1:0]  y_s;
    logic [WIDTH-1:0]  result_next_s;
    logic              last_s;

    // Steer the currently indexed slice of each captured operand to the operator.
    always_comb begin
        shamt_s   = 32'(idx_r) * 32'(SLICE);
        a_slice_s = SLICE'(a_r >> shamt_s);
        b_slice_s = SLICE'(b_r >> shamt_s);
        last_s    = (idx_r == IDX_LAST);
    end

    logic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a  (a_slice_s),
        .b  (b_slice_s),
        .op (op_r),
        .y  (y_s)
    );

    // Merge the freshly computed slice into the result at the current index.
    always_comb begin
        result_next_s = result_r;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_r == IDXW'(i)) begin
                result_next_s[i*SLICE +: SLICE] = y_s;
            end else begin
                result_next_s[i*SLICE +: SLICE] = result_r[i*SLICE +: SLICE];
            end
        end
    end

    // Controller: state, slice index, operand capture, result/zero and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            idx_r    <= '0;
            op_r     <= OP_AND;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            zero_r   <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        op_r     <= op;
                        a_r      <= value1;
                        b_r      <= value2;
                        result_r <= '0;
                        idx_r    <= '0;
                        state_r  <= ST_RUN;
                        ready_r  <= 1'b0;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                        ready_r  <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    result_r <= result_next_s;
                    if (last_s) begin
                        zero_r  <= (result_next_s == '0);
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        idx_r   <= idx_r + 1'b1;
                        state_r <= ST_RUN;
                        done_r  <= 1'b0;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= '0;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready  = ready_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign zero   = zero_r;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit: directed scenarios on the
// default 32/8 configuration plus a random sweep across four configurations.
module tb_bitwise_logic_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [63:0] value1;
    logic [63:0] value2;

    logic d0_ready, d0_busy, d0_done, d0_zero;
    logic d1_ready, d1_busy, d1_done, d1_zero;
    logic d2_ready, d2_busy, d2_done, d2_zero;
    logic d3_ready, d3_busy, d3_done, d3_zero;
    logic [31:0] d0_result, d1_result, d2_result;
    logic [63:0] d3_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitwise_logic_unit #(.WIDTH(32), .SLICE(8)) dut0 (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .value1(value1[31:0]), .value2(value2[31:0]),
        .ready(d0_ready), .busy(d0_busy), .done(d0_done),
        .result(d0_result), .zero(d0_zero));

    bitwise_logic_unit #(.WIDTH(32), .SLICE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .value1(value1[31:0]), .value2(value2[31:0]),
        .ready(d1_ready), .busy(d1_busy), .done(d1_done),
        .result(d1_result), .zero(d1_zero));

    bitwise_logic_unit #(.WIDTH(32), .SLICE(32)) dut2 (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .value1(value1[31:0]), .value2(value2[31:0]),
        .ready(d2_ready), .busy(d2_busy), .done(d2_done),
        .result(d2_result), .zero(d2_zero));

    bitwise_logic_unit #(.WIDTH(64), .SLICE(16)) dut3 (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .value1(value1), .value2(value2),
        .ready(d3_ready), .busy(d3_busy), .done(d3_done),
        .result(d3_result), .zero(d3_zero));

    // Whole-word reference: the operation applied to full operands, cut to w bits.
    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [63:0] a,
                                           input logic [63:0] b, input int w);
        logic [63:0] r;
        case (o)
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = a ^ b;
            default: r = ~(a | b);
        endcase
        if (w < 64) r = r & ((64'd1 << w) - 64'd1);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op to the default unit and wait (bounded) for its done pulse.
    task automatic run_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                          output int lat, output logic [31:0] res, output logic z);
        op = o; value1 = a; value2 = b; start = 1'b1;
        step();
        start = 1'b0;
        lat = -1; res = '0; z = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (d0_done) begin
                lat = k; res = d0_result; z = d0_zero;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'd0; value1 = '0; value2 = '0;
        step(); step();
        reset = 1'b0;
        checks += 5;
        if (d0_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", d0_ready); end
        if (d0_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", d0_busy); end
        if (d0_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", d0_done); end
        if (d0_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", d0_result); end
        if (d0_zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", d0_zero); end
    endtask

    task automatic test_or_basic();
        int lat; logic [31:0] res; logic z;
        run_op(2'b01, 64'h0000_00F0, 64'h0F00_000F, lat, res, z);
        checks += 3;
        if (lat != 4) begin errors++; $display("FAIL or_latency: got %0d expected 4", lat); end
        if (res !== 32'h0F00_00FF) begin errors++; $display("FAIL or_result: got %h expected 0f0000ff", res); end
        if (z !== 1'b0) begin errors++; $display("FAIL or_zero: got %b expected 0", z); end
        step();
        checks += 3;
        if (d0_done !== 1'b0) begin errors++; $display("FAIL or_done_width: got %b expected 0", d0_done); end
        if (d0_ready !== 1'b1) begin errors++; $display("FAIL or_ready_after: got %b expected 1", d0_ready); end
        if (d0_result !== 32'h0F00_00FF) begin errors++; $display("FAIL or_result_hold: got %h expected 0f0000ff", d0_result); end
    endtask

    task automatic test_all_ops();
        int lat; logic [31:0] res; logic z;
        logic [31:0] expv [4];
        expv[0] = 32'h0F0F_0000; expv[1] = 32'hFFFF_0F0F;
        expv[2] = 32'hF0F0_0F0F; expv[3] = 32'h0000_F0F0;
        for (int o = 0; o < 4; o++) begin
            run_op(2'(o), 64'hFFFF_0000, 64'h0F0F_0F0F, lat, res, z);
            checks += 2;
            if (res !== expv[o]) begin errors++; $display("FAIL op%0d_result: got %h expected %h", o, res, expv[o]); end
            if (z !== 1'b0) begin errors++; $display("FAIL op%0d_zero: got %b expected 0", o, z); end
        end
        run_op(2'b00, 64'h1234_0000, 64'h0000_5678, lat, res, z);
        checks += 2;
        if (res !== 32'd0) begin errors++; $display("FAIL and_zero_result: got %h expected 0", res); end
        if (z !== 1'b1) begin errors++; $display("FAIL and_zero_flag: got %b expected 1", z); end
        for (int n = 0; n < 8; n++) begin
            logic [1:0] o; logic [63:0] a, b, e;
            o = 2'($urandom_range(0, 3)); a = {$urandom, $urandom}; b = {$urandom, $urandom};
            e = ref_op(o, a, b, 32);
            run_op(o, a, b, lat, res, z);
            checks += 3;
            if (res !== e[31:0]) begin errors++; $display("FAIL rand_result: got %h expected %h", res, e[31:0]); end
            if (z !== (e == 64'd0)) begin errors++; $display("FAIL rand_zero: got %b expected %b", z, (e == 64'd0)); end
            if (lat != 4) begin errors++; $display("FAIL rand_latency: got %0d expected 4", lat); end
        end
        step();
    endtask

    task automatic test_run_ignores();
        logic [1:0] o; logic [63:0] a, b, e;
        int runs; logic seen;
        o = 2'($urandom_range(0, 3)); a = {$urandom, $urandom}; b = {$urandom, $urandom};
        e = ref_op(o, a, b, 32);
        op = o; value1 = a; value2 = b; start = 1'b1;
        step();
        runs = 0; seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (d0_busy !== 1'b1 || d0_ready !== 1'b0) begin
                errors++; $display("FAIL run_flags: got busy=%b ready=%b expected busy=1 ready=0", d0_busy, d0_ready);
            end
            op = 2'($urandom_range(0, 3)); value1 = {$urandom, $urandom}; value2 = {$urandom, $urandom};
            start = 1'b1;
            step();
            runs++;
            if (d0_done) begin start = 1'b0; seen = 1'b1; break; end
        end
        start = 1'b0;
        checks += 3;
        if (seen !== 1'b1) begin errors++; $display("FAIL run_done_seen: got %b expected 1", seen); end
        if (runs != 4) begin errors++; $display("FAIL run_cycles: got %0d expected 4", runs); end
        if (d0_result !== e[31:0]) begin errors++; $display("FAIL run_result: got %h expected %h", d0_result, e[31:0]); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] q[$];
        logic [63:0] a, b, e; logic [1:0] o;
        int pushes, dones, last;
        pushes = 0; dones = 0; last = -1;
        for (int s = 0; s < 80 && dones < 5; s++) begin
            if (d0_ready && pushes < 5) begin
                o = 2'($urandom_range(0, 3)); a = {$urandom, $urandom}; b = {$urandom, $urandom};
                e = ref_op(o, a, b, 32);
                op = o; value1 = a; value2 = b; start = 1'b1;
                q.push_back(e[31:0]);
                pushes++;
            end else if (pushes >= 5) begin
                start = 1'b0;
            end
            step();
            if (d0_done) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious_done: got done with empty queue expected none");
                end else begin
                    logic [31:0] x;
                    x = q.pop_front();
                    if (d0_result !== x) begin errors++; $display("FAIL b2b_result: got %h expected %h", d0_result, x); end
                end
                if (last >= 0) begin
                    checks++;
                    if (s - last != 5) begin errors++; $display("FAIL b2b_spacing: got %0d expected 5", s - last); end
                end
                last = s;
                dones++;
            end
        end
        start = 1'b0;
        checks++;
        if (dones != 5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", dones); end
        step();
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] res; logic z; logic [63:0] e; logic any_done;
        op = 2'b01; value1 = 64'hFFFF_FFFF; value2 = 64'h0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks += 4;
        if (d0_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", d0_ready); end
        if (d0_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", d0_busy); end
        if (d0_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b expected 0", d0_done); end
        if (d0_result !== 32'd0) begin errors++; $display("FAIL abort_result: got %h expected 0", d0_result); end
        any_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (d0_done) any_done = 1'b1;
        end
        checks++;
        if (any_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", any_done); end
        e = ref_op(2'b10, 64'h1357_9BDF, 64'h0246_8ACE, 32);
        run_op(2'b10, 64'h1357_9BDF, 64'h0246_8ACE, lat, res, z);
        checks += 2;
        if (res !== e[31:0]) begin errors++; $display("FAIL abort_next_result: got %h expected %h", res, e[31:0]); end
        if (lat != 4) begin errors++; $display("FAIL abort_next_latency: got %0d expected 4", lat); end
        step();
    endtask

    task automatic test_sweep();
        logic [1:0] o; logic [63:0] a, b, e32, e64;
        int l0, l1, l2, l3;
        logic [31:0] r0, r1, r2; logic [63:0] r3;
        logic z0, z1, z2, z3;
        reset = 1'b1; start = 1'b0;
        step();
        reset = 1'b0;
        step();
        for (int n = 0; n < 12; n++) begin
            o = 2'($urandom_range(0, 3)); a = {$urandom, $urandom}; b = {$urandom, $urandom};
            if (n == 0) begin o = 2'b00; b = ~a; end
            if (n == 1) begin o = 2'b11; a = '1; end
            e32 = ref_op(o, a, b, 32);
            e64 = ref_op(o, a, b, 64);
            op = o; value1 = a; value2 = b; start = 1'b1;
            step();
            start = 1'b0;
            l0 = -1; l1 = -1; l2 = -1; l3 = -1;
            r0 = '0; r1 = '0; r2 = '0; r3 = '0; z0 = 1'b0; z1 = 1'b0; z2 = 1'b0; z3 = 1'b0;
            for (int k = 1; k <= 40; k++) begin
                step();
                if (d0_done && l0 < 0) begin l0 = k; r0 = d0_result; z0 = d0_zero; end
                if (d1_done && l1 < 0) begin l1 = k; r1 = d1_result; z1 = d1_zero; end
                if (d2_done && l2 < 0) begin l2 = k; r2 = d2_result; z2 = d2_zero; end
                if (d3_done && l3 < 0) begin l3 = k; r3 = d3_result; z3 = d3_zero; end
            end
            checks += 12;
            if (l0 != 4)  begin errors++; $display("FAIL sweep_32x8_latency: got %0d expected 4", l0); end
            if (l1 != 32) begin errors++; $display("FAIL sweep_32x1_latency: got %0d expected 32", l1); end
            if (l2 != 1)  begin errors++; $display("FAIL sweep_32x32_latency: got %0d expected 1", l2); end
            if (l3 != 4)  begin errors++; $display("FAIL sweep_64x16_latency: got %0d expected 4", l3); end
            if (r0 !== e32[31:0]) begin errors++; $display("FAIL sweep_32x8_result: got %h expected %h", r0, e32[31:0]); end
            if (r1 !== e32[31:0]) begin errors++; $display("FAIL sweep_32x1_result: got %h expected %h", r1, e32[31:0]); end
            if (r2 !== e32[31:0]) begin errors++; $display("FAIL sweep_32x32_result: got %h expected %h", r2, e32[31:0]); end
            if (r3 !== e64) begin errors++; $display("FAIL sweep_64x16_result: got %h expected %h", r3, e64); end
            if (z0 !== (e32 == 64'd0)) begin errors++; $display("FAIL sweep_32x8_zero: got %b expected %b", z0, (e32 == 64'd0)); end
            if (z1 !== (e32 == 64'd0)) begin errors++; $display("FAIL sweep_32x1_zero: got %b expected %b", z1, (e32 == 64'd0)); end
            if (z2 !== (e32 == 64'd0)) begin errors++; $display("FAIL sweep_32x32_zero: got %b expected %b", z2, (e32 == 64'd0)); end
            if (z3 !== (e64 == 64'd0)) begin errors++; $display("FAIL sweep_64x16_zero: got %b expected %b", z3, (e64 == 64'd0)); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_or_basic();
        test_all_ops();
        test_run_ignores();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
